// File: rtl/seq_chk_pkg.sv
// ---------------------------------------------------------------------------
// seq_chk_pkg
// Shared types and default parameters for the sequence gap checker.
//   fail_kind_e : which check an attempt failed on (a-check or b-check)
//   slot_t      : one pipeline slot, {valid, start stamp}
//   DEF_*       : default GAP / counter width / cycle counter width
// ---------------------------------------------------------------------------
package seq_chk_pkg;

    localparam int DEF_GAP   = 2;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_CYC_W = 32;

    // Stamp storage is sized for the widest supported cycle counter; a
    // narrower CYC_W is zero-extended into it.
    localparam int STAMP_W   = DEF_CYC_W;

    typedef enum logic {
        FAIL_A = 1'b0,
        FAIL_B = 1'b1
    } fail_kind_e;

    typedef struct packed {
        logic               valid;
        logic [STAMP_W-1:0] stamp;
    } slot_t;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter that accepts an increment of 0, 1 or 2 per clock.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear (count -> 0), wins over the increment
//   inc   : increment amount, 0..2
//   count : current count, sticks at 2^W-1
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    localparam logic [W+1:0] MAX_VAL = {2'b00, {W{1'b1}}};

    logic [W+1:0] sum;

    // Two guard bits so that max + 2 cannot wrap before the saturation test.
    always_comb begin
        sum = {2'b00, count} + {{W{1'b0}}, inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (sum > MAX_VAL) begin
            count <= {W{1'b1}};
        end else begin
            count <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/seq_gap_checker.sv
// ---------------------------------------------------------------------------
// seq_gap_checker
// Hardware checker for "status |=> (a ##GAP b)" with overlapping attempts.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : allows status to start new attempts
//   clr             : synchronous clear of pipeline, counters and capture
//   status, a, b    : monitored protocol signals
//   pass            : pulse, an attempt saw b = 1 at its b-check
//   fail_a          : pulse, an attempt saw a = 0 at its a-check
//   fail_b          : pulse, an attempt saw b = 0 at its b-check
//   pass_cnt        : saturating pass count
//   fail_cnt        : saturating failure count (may step by 2)
//   first_fail_vld  : sticky, a failure has been captured
//   first_fail_cyc  : start cycle of the first failing attempt
//   first_fail_kind : 0 = failed on a, 1 = failed on b
//   busy            : at least one attempt is in flight
// ---------------------------------------------------------------------------
module seq_gap_checker
    import seq_chk_pkg::*;
#(
    parameter int GAP   = DEF_GAP,
    parameter int CNT_W = DEF_CNT_W,
    parameter int CYC_W = DEF_CYC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             status,
    input  logic             a,
    input  logic             b,
    output logic             pass,
    output logic             fail_a,
    output logic             fail_b,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_vld,
    output logic [CYC_W-1:0] first_fail_cyc,
    output logic             first_fail_kind,
    output logic             busy
);

    // Elaboration-time parameter checks.
    generate
        if (GAP < 1 || GAP > 15) begin : g_bad_gap
            $error("seq_gap_checker: GAP must be in 1..15");
        end
        if (CYC_W < 1 || CYC_W > STAMP_W) begin : g_bad_cyc_w
            $error("seq_gap_checker: CYC_W out of supported range");
        end
    endgenerate

    logic [CYC_W-1:0] cyc;
    slot_t            slots [0:GAP];

    logic       fail_a_now;
    logic       fail_b_now;
    logic       pass_now;
    logic [1:0] pass_inc;
    logic [1:0] fail_inc;

    // Slot 0 holds attempts awaiting their a-check, slot GAP holds attempts
    // awaiting their b-check; both verdicts are decided from this edge's samples.
    always_comb begin
        fail_a_now = slots[0].valid & ~a;
        pass_now   = slots[GAP].valid & b;
        fail_b_now = slots[GAP].valid & ~b;
        pass_inc   = {1'b0, pass_now};
        fail_inc   = {1'b0, fail_a_now} + {1'b0, fail_b_now};
    end

    // Free-running cycle counter; only reset clears it, clr does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + 1'b1;
        end
    end

    // Attempt pipeline. An attempt moves out of slot 0 only if a was high;
    // from slot 1 on it simply shifts until the b-check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= GAP; i++) begin
                slots[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i <= GAP; i++) begin
                slots[i] <= '0;
            end
        end else begin
            slots[0].valid <= status & en;
            slots[0].stamp <= STAMP_W'(cyc);
            slots[1].valid <= slots[0].valid & a;
            slots[1].stamp <= slots[0].stamp;
            for (int i = 2; i <= GAP; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    // Registered per-attempt result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass   <= 1'b0;
            fail_a <= 1'b0;
            fail_b <= 1'b0;
        end else if (clr) begin
            pass   <= 1'b0;
            fail_a <= 1'b0;
            fail_b <= 1'b0;
        end else begin
            pass   <= pass_now;
            fail_a <= fail_a_now;
            fail_b <= fail_b_now;
        end
    end

    // First-failure capture. When both checks fail together the b-check
    // attempt started earlier, so it is the one recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld  <= 1'b0;
            first_fail_cyc  <= '0;
            first_fail_kind <= FAIL_A;
        end else if (clr) begin
            first_fail_vld  <= 1'b0;
            first_fail_cyc  <= '0;
            first_fail_kind <= FAIL_A;
        end else if (!first_fail_vld && fail_b_now) begin
            first_fail_vld  <= 1'b1;
            first_fail_cyc  <= slots[GAP].stamp[CYC_W-1:0];
            first_fail_kind <= FAIL_B;
        end else if (!first_fail_vld && fail_a_now) begin
            first_fail_vld  <= 1'b1;
            first_fail_cyc  <= slots[0].stamp[CYC_W-1:0];
            first_fail_kind <= FAIL_A;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= GAP; i++) begin
            busy = busy | slots[i].valid;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (pass_inc),
        .count (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (fail_inc),
        .count (fail_cnt)
    );

endmodule

// File: tb/tb_seq_gap_checker.sv
// ---------------------------------------------------------------------------
// tb_seq_gap_checker
// Self-checking bench for seq_gap_checker. Expected outputs come from an
// attempt-level model: per-edge input history plus the rule
// "status at k, a at k+1, b at k+1+GAP", evaluated with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_seq_gap_checker;

    localparam int GAP   = 2;
    localparam int CNT_W = 3;
    localparam int CYC_W = 32;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int HIST  = 4096;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             clr;
    logic             status;
    logic             a;
    logic             b;
    logic             pass;
    logic             fail_a;
    logic             fail_b;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             first_fail_vld;
    logic [CYC_W-1:0] first_fail_cyc;
    logic             first_fail_kind;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;

    // Model state: edge index since reset release and per-edge history.
    int n;
    int lastClr;
    bit stH [0:HIST-1];
    bit aH  [0:HIST-1];

    bit expPass, expFailA, expFailB, expFfv, expKind, expBusy;
    int expPassCnt, expFailCnt, expFfc;

    seq_gap_checker #(
        .GAP   (GAP),
        .CNT_W (CNT_W),
        .CYC_W (CYC_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .clr             (clr),
        .status          (status),
        .a               (a),
        .b               (b),
        .pass            (pass),
        .fail_a          (fail_a),
        .fail_b          (fail_b),
        .pass_cnt        (pass_cnt),
        .fail_cnt        (fail_cnt),
        .first_fail_vld  (first_fail_vld),
        .first_fail_cyc  (first_fail_cyc),
        .first_fail_kind (first_fail_kind),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An attempt with start edge k exists if it was triggered and not
    // wiped by a clr at or after k.
    function automatic bit started(input int k);
        return (k >= 0) && (k > lastClr) && stH[k];
    endfunction

    function automatic int satAdd(input int v, input int d);
        return (v + d > CMAX) ? CMAX : v + d;
    endfunction

    task automatic resetModel();
        n          = 0;
        lastClr    = -1;
        expPass    = 0;
        expFailA   = 0;
        expFailB   = 0;
        expFfv     = 0;
        expKind    = 0;
        expBusy    = 0;
        expPassCnt = 0;
        expFailCnt = 0;
        expFfc     = 0;
    endtask

    // Advance the model by one rising edge with the inputs sampled there.
    task automatic modelEdge(input bit st, input bit e, input bit aa, input bit bb, input bit cc);
        int k;
        stH[n] = st && e;
        aH[n]  = aa;
        if (cc) begin
            lastClr    = n;
            expPass    = 0;
            expFailA   = 0;
            expFailB   = 0;
            expPassCnt = 0;
            expFailCnt = 0;
            expFfv     = 0;
            expFfc     = 0;
            expKind    = 0;
            expBusy    = 0;
        end else begin
            expPass  = 0;
            expFailA = 0;
            expFailB = 0;
            if (started(n - 1) && !aa) expFailA = 1;
            k = n - 1 - GAP;
            if (started(k) && aH[k+1]) begin
                if (bb) expPass = 1;
                else    expFailB = 1;
            end
            expPassCnt = satAdd(expPassCnt, int'(expPass));
            expFailCnt = satAdd(expFailCnt, int'(expFailA) + int'(expFailB));
            if (!expFfv && expFailB) begin
                expFfv  = 1;
                expFfc  = k;
                expKind = 1;
            end else if (!expFfv && expFailA) begin
                expFfv  = 1;
                expFfc  = n - 1;
                expKind = 0;
            end
            expBusy = 0;
            for (int j = n - GAP; j <= n; j++) begin
                if (started(j) && (j == n || aH[j+1])) expBusy = 1;
            end
        end
        n++;
    endtask

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, n - 1);
        end
    endtask

    task automatic checkOutput();
        check1("pass",      32'(pass),            32'(expPass));
        check1("fail_a",    32'(fail_a),          32'(expFailA));
        check1("fail_b",    32'(fail_b),          32'(expFailB));
        check1("pass_cnt",  32'(pass_cnt),        32'(expPassCnt));
        check1("fail_cnt",  32'(fail_cnt),        32'(expFailCnt));
        check1("ff_vld",    32'(first_fail_vld),  32'(expFfv));
        check1("ff_cyc",    32'(first_fail_cyc),  32'(expFfc));
        check1("ff_kind",   32'(first_fail_kind), 32'(expKind));
        check1("busy",      32'(busy),            32'(expBusy));
    endtask

    // Drive one edge's inputs (called just after a falling edge), then check
    // the registered outputs 1 ns after the rising edge.
    task automatic applyStimulus(input bit st, input bit e, input bit aa, input bit bb, input bit cc);
        status = st;
        en     = e;
        a      = aa;
        b      = bb;
        clr    = cc;
        @(posedge clk);
        modelEdge(st, e, aa, bb, cc);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    // Called just after a falling edge; release happens before the next rising edge.
    task automatic doReset();
        rst_n  = 1'b0;
        status = 1'b0;
        a      = 1'b0;
        b      = 1'b0;
        clr    = 1'b0;
        #1;
        resetModel();
        checkOutput();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        clr    = 1'b0;
        status = 1'b0;
        a      = 1'b0;
        b      = 1'b0;
        resetModel();
        @(negedge clk);

        $display("[TB] single pass");
        doReset();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        check1("t1_pass_pulse", 32'(pass), 32'd1);
        applyStimulus(0, 1, 0, 0, 0);
        check1("t1_pass_cnt", 32'(pass_cnt), 32'd1);
        check1("t1_busy",     32'(busy),     32'd0);

        $display("[TB] a failure");
        doReset();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        check1("t2_fail_a",   32'(fail_a),         32'd1);
        check1("t2_ff_cyc",   32'(first_fail_cyc), 32'd2);
        check1("t2_ff_kind",  32'(first_fail_kind), 32'd0);
        applyStimulus(0, 1, 0, 0, 0);

        $display("[TB] overlapping attempts");
        doReset();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        check1("t3_fail_b",  32'(fail_b),          32'd1);
        check1("t3_ff_kind", 32'(first_fail_kind), 32'd1);
        applyStimulus(0, 1, 0, 0, 0);

        $display("[TB] simultaneous failures");
        doReset();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        check1("t4_fail_cnt", 32'(fail_cnt),       32'd2);
        check1("t4_ff_cyc",   32'(first_fail_cyc), 32'd2);
        applyStimulus(0, 1, 0, 0, 0);

        $display("[TB] saturation and clear");
        doReset();
        for (int i = 0; i < 14; i++) applyStimulus(1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++)  applyStimulus(0, 1, 1, 1, 0);
        check1("t5_sat", 32'(pass_cnt), CMAX);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        check1("t5_clr", 32'(pass_cnt), 32'd0);
        applyStimulus(0, 1, 0, 0, 0);

        $display("[TB] reset mid-flight");
        doReset();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        doReset();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, 0);
        check1("t6_pass_cnt", 32'(pass_cnt), 32'd0);

        $display("[TB] randomized traffic");
        doReset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) doReset();
            applyStimulus($urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) != 0,
                          $urandom_range(0, 4) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
